pwm_multi_gen: RTL and testbench

// - N-channel PWM generator sharing one period counter; per-channel duty, polarity, glitch-free updates.
// - Adds edge- or centre-aligned mode, duty/mode/polarity shadowing to period boundary, period_start strobe.
// - Sits between control registers/IP wrapper and pins: motor drive, LED dimming, servo.

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_channel.sv | 68 ++++++
 rtl/pwm_multi_gen.sv | 106 ++++++++++
 tb/tb_pwm_multi_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTRE = 1'b1
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int calc_period(input int clk_hz, input int freq);
        return clk_hz / freq;
    endfunction

    function automatic int calc_half(input int period);
        return period / 2;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: pending/active duty and polarity, threshold compare, output register.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int PERIOD = 10,
    parameter int HALF   = 5,
    parameter int CW     = 4,
    parameter int RES    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           load,
    input  logic           boundary,
    input  logic           centre,
    input  logic [CW-1:0]  cnt,
    input  logic [RES-1:0] duty,
    input  logic           polarity,
    output logic           pwm
);

    localparam int PW = CW + RES;

    logic [RES-1:0] pend_duty;
    logic [RES-1:0] act_duty;
    logic [RES-1:0] eff_duty;
    logic           pend_pol;
    logic           act_pol;
    logic           eff_pol;
    logic [PW-1:0]  prod_edge;
    logic [PW-1:0]  prod_centre;
    logic [CW-1:0]  thr;
    logic [CW-1:0]  thrc;
    logic           raw;

    // On the boundary cycle the freshly promoted settings already drive the compare,
    // so the new period starts cleanly at cnt==0.
    always_comb begin
        eff_duty    = boundary ? pend_duty : act_duty;
        eff_pol     = boundary ? pend_pol  : act_pol;
        prod_edge   = PW'(PERIOD) * PW'(eff_duty);
        prod_centre = PW'(HALF) * PW'(eff_duty);
        thr         = CW'(prod_edge >> RES);
        thrc        = CW'(prod_centre >> RES);
        raw         = centre ? (cnt >= (CW'(HALF) - thrc)) : (cnt < thr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_duty <= '0;
            pend_pol  <= 1'b0;
            act_duty  <= '0;
            act_pol   <= 1'b0;
            pwm       <= 1'b0;
        end else begin
            if (load) begin
                pend_duty <= duty;
                pend_pol  <= polarity;
            end
            if (boundary) begin
                act_duty <= pend_duty;
                act_pol  <= pend_pol;
            end
            pwm <= en ? (raw ^ eff_pol) : act_pol;
        end
    end

endmodule

// File: rtl/pwm_multi_gen.sv
// N-channel PWM generator: shared period counter (edge or centre aligned), mode shadow,
// period_start strobe, and one pwm_channel per output.
//   state    | meaning
//   DIR_UP   | counting up; cnt==0 here is the period boundary
//   DIR_DOWN | centre mode only, counting back down to 0
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FREQ     = 5000,
    parameter int CHANNELS = 4,
    parameter int RES      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    load,
    input  logic [CHANNELS*RES-1:0] duty,
    input  logic [CHANNELS-1:0]     polarity,
    output logic [CHANNELS-1:0]     PWM,
    output logic                    period_start
);

    localparam int PERIOD = calc_period(CLK_HZ, FREQ);
    localparam int HALF   = calc_half(PERIOD);
    localparam int CW     = clog2(PERIOD);

    if (PERIOD < 4) begin : g_bad_period
        $error("pwm_multi_gen: PERIOD = CLK_HZ/FREQ must be at least 4");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("pwm_multi_gen: CHANNELS must be 1..16");
    end

    logic [CW-1:0] cnt;
    dir_t          dir;
    mode_t         mode_act;
    mode_t         mode_pend;
    mode_t         mode_eff;
    logic          boundary;

    assign boundary = en && (cnt == '0) && (dir == DIR_UP);
    assign mode_eff = boundary ? mode_pend : mode_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            mode_act     <= PWM_EDGE;
            mode_pend    <= PWM_EDGE;
            period_start <= 1'b0;
        end else begin
            if (load) begin
                mode_pend <= mode_t'(mode);
            end
            period_start <= boundary;
            if (!en) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else begin
                if (boundary) begin
                    mode_act <= mode_pend;
                end
                if (mode_eff == PWM_EDGE) begin
                    dir <= DIR_UP;
                    cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
                end else if (dir == DIR_UP) begin
                    // Turnaround values are held one extra cycle so the period is 2*HALF.
                    if (cnt == CW'(HALF - 1)) begin
                        dir <= DIR_DOWN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    if (cnt == '0) begin
                        dir <= DIR_UP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .PERIOD (PERIOD),
            .HALF   (HALF),
            .CW     (CW),
            .RES    (RES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .load     (load),
            .boundary (boundary),
            .centre   (mode_eff == PWM_CENTRE),
            .cnt      (cnt),
            .duty     (duty[i*RES +: RES]),
            .polarity (polarity[i]),
            .pwm      (PWM[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Scoreboard bench for pwm_multi_gen: a period-phase reference model predicts each cycle's
// outputs, a negedge monitor compares them, and directed sequences cover the called-out cases.
module tb_pwm_multi_gen;

    localparam int CLK_HZ = 1000;
    localparam int FREQ   = 100;
    localparam int CH     = 2;
    localparam int RES    = 4;
    localparam int PERIOD = CLK_HZ / FREQ;
    localparam int HALF   = PERIOD / 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic              load = 1'b0;
    logic [CH*RES-1:0] duty = '0;
    logic [CH-1:0]     polarity = '0;
    logic [CH-1:0]     PWM;
    logic              period_start;

    always #5 clk = ~clk;

    pwm_multi_gen #(
        .CLK_HZ   (CLK_HZ),
        .FREQ     (FREQ),
        .CHANNELS (CH),
        .RES      (RES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .mode         (mode),
        .load         (load),
        .duty         (duty),
        .polarity     (polarity),
        .PWM          (PWM),
        .period_start (period_start)
    );

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state: position inside the current period plus pending/active settings.
    int            m_phase = 0;
    int            p_duty[CH];
    int            a_duty[CH];
    logic [CH-1:0] p_pol = '0;
    logic [CH-1:0] a_pol = '0;
    logic          p_mode = 1'b0;
    logic          a_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Edge: high for the first floor(PERIOD*d/2^RES) cycles.
    // Centre: 2*floor(HALF*d/2^RES) high cycles symmetric about the middle of the period.
    function automatic logic level(input int d, input logic centre, input int phase);
        int t;
        if (!centre) begin
            t = (PERIOD * d) >> RES;
            return phase < t;
        end
        t = (HALF * d) >> RES;
        return (phase >= HALF - t) && (phase < HALF + t);
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   plen;
        e = '0;
        if (reset) begin
            m_phase = 0;
            p_pol = '0; a_pol = '0; p_mode = 1'b0; a_mode = 1'b0;
            for (int c = 0; c < CH; c++) begin p_duty[c] = 0; a_duty[c] = 0; end
        end else begin
            if (en) begin
                if (m_phase == 0) begin
                    for (int c = 0; c < CH; c++) a_duty[c] = p_duty[c];
                    a_pol  = p_pol;
                    a_mode = p_mode;
                end
                for (int c = 0; c < CH; c++) e.pwm[c] = level(a_duty[c], a_mode, m_phase) ^ a_pol[c];
                e.ps = (m_phase == 0);
                plen = a_mode ? 2 * HALF : PERIOD;
                m_phase = (m_phase + 1) % plen;
            end else begin
                e.pwm   = a_pol;
                e.ps    = 1'b0;
                m_phase = 0;
            end
            if (load) begin
                for (int c = 0; c < CH; c++) p_duty[c] = int'(duty[c*RES +: RES]);
                p_pol  = polarity;
                p_mode = mode;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pwm", int'(PWM), int'(e.pwm));
            chk("period_start", int'(period_start), int'(e.ps));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [CH*RES-1:0] d, input logic [CH-1:0] p, input logic m);
        duty = d; polarity = p; mode = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int k;
        k = 0;
        while (m_phase != p && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (m_phase != p) chk("wait_phase_timeout", m_phase, p);
    endtask

    task automatic count_high(input int ch, output int hi, output int ps);
        hi = 0; ps = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            hi += int'(PWM[ch]);
            ps += int'(period_start);
        end
    endtask

    initial begin : stim
        int hi;
        int ps;
        tick(3);
        chk("reset_pwm", int'(PWM), 0);
        chk("reset_ps", int'(period_start), 0);
        chk("reset_cnt", int'(dut.cnt), 0);
        reset = 1'b0;
        tick(2);

        // Edge aligned, ch0 d=8, ch1 d=15.
        do_load({4'd15, 4'd8}, 2'b00, 1'b0);
        en = 1'b1;
        tick(12);
        count_high(0, hi, ps);
        chk("edge_d8_high", hi, 5);
        chk("edge_ps_per_period", ps, 1);
        count_high(1, hi, ps);
        chk("edge_d15_high", hi, 9);

        // Zero duty with both polarities, then idle.
        do_load({4'd0, 4'd0}, 2'b10, 1'b0);
        tick(12);
        count_high(0, hi, ps);
        chk("d0_pol0_high", hi, 0);
        count_high(1, hi, ps);
        chk("d0_pol1_high", hi, PERIOD);
        en = 1'b0;
        tick(5);
        chk("idle_pwm", int'(PWM), 2);
        chk("idle_ps", int'(period_start), 0);

        // Centre aligned d=8, loaded while idle.
        do_load({4'd8, 4'd8}, 2'b00, 1'b1);
        tick(3);
        en = 1'b1;
        tick(12);
        count_high(0, hi, ps);
        chk("centre_d8_high", hi, 4);
        chk("centre_ps_per_period", ps, 1);

        // Edge d=8, then mid-period load of d=4 at cnt=3.
        do_load({4'd8, 4'd8}, 2'b00, 1'b0);
        tick(22);
        wait_phase(3);
        do_load({4'd4, 4'd4}, 2'b00, 1'b0);
        tick(25);

        // Load during the boundary cycle.
        wait_phase(0);
        do_load({4'd12, 4'd12}, 2'b00, 1'b0);
        tick(25);

        // Mode change loaded mid-period.
        wait_phase(4);
        do_load({4'd8, 4'd8}, 2'b01, 1'b1);
        tick(25);

        // Async reset at cnt=6 while the outputs are high.
        do_load({4'd15, 4'd15}, 2'b00, 1'b0);
        tick(22);
        wait_phase(6);
        #2 reset = 1'b1;
        #1;
        chk("async_pwm", int'(PWM), 0);
        chk("async_cnt", int'(dut.cnt), 0);
        chk("async_ps", int'(period_start), 0);
        @(negedge clk);
        tick(2);
        reset = 1'b0;
        do_load({4'd8, 4'd8}, 2'b00, 1'b0);
        tick(22);
        count_high(0, hi, ps);
        chk("post_reset_d8_high", hi, 5);

        // Randomized settings, load timing and enable gaps.
        for (int it = 0; it < 60; it++) begin
            duty     = (CH*RES)'($urandom);
            polarity = CH'($urandom);
            mode     = 1'($urandom);
            load     = 1'b1;
            en       = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            load = 1'b0;
            tick($urandom_range(1, 15));
        end
        en = 1'b1;
        tick(25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
